// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake and full backpressure.
// Define CLA_OVERFLOW_EN to add the registered signed-overflow output out_ovf.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef CLA_OVERFLOW_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int NGRP = WIDTH / GROUP;

    logic             s1_valid;
    logic             s1_cin;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic [NGRP-1:0]  s1_gg;
    logic [NGRP-1:0]  s1_gp;

    logic             adv1;
    logic             adv2;
    logic             accept;

    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_in;
    logic [NGRP-1:0]  gg_in;
    logic [NGRP-1:0]  gp_in;

    logic [NGRP:0]    gc;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;
    assign accept   = in_valid && adv1;

    assign p_in = in_a ^ in_b;
    assign g_in = in_a & in_b;

    // Group generate folds from the lowest bit upward: gg = g[j] | p[j] & gg_below.
    always_comb begin
        gg_in = '0;
        gp_in = '0;
        for (int k = 0; k < NGRP; k++) begin
            for (int j = 0; j < GROUP; j++) begin
                gg_in[k] = g_in[k*GROUP+j] | (p_in[k*GROUP+j] & gg_in[k]);
            end
            gp_in[k] = &p_in[k*GROUP +: GROUP];
        end
    end

    // S1 data only loads on an accepted transfer, so idle (possibly X) operands never enter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_cin   <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_gg    <= '0;
            s1_gp    <= '0;
        end else if (adv1) begin
            s1_valid <= accept;
            if (accept) begin
                s1_cin <= in_cin;
                s1_p   <= p_in;
                s1_g   <= g_in;
                s1_gg  <= gg_in;
                s1_gp  <= gp_in;
            end
        end
    end

    // Group carries come from the lookahead chain; bit carries ripple only inside a group.
    always_comb begin
        gc    = '0;
        c     = '0;
        gc[0] = s1_cin;
        for (int k = 0; k < NGRP; k++) begin
            gc[k+1] = s1_gg[k] | (s1_gp[k] & gc[k]);
        end
        for (int k = 0; k < NGRP; k++) begin
            c[k*GROUP] = gc[k];
            for (int j = 0; j < GROUP; j++) begin
                c[k*GROUP+j+1] = s1_g[k*GROUP+j] | (s1_p[k*GROUP+j] & c[k*GROUP+j]);
            end
        end
        c[WIDTH] = gc[NGRP];
        sum_d    = s1_p ^ c[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
`ifdef CLA_OVERFLOW_EN
            out_ovf   <= 1'b0;
`endif
        end else if (adv2) begin
            out_valid <= s1_valid;
            out_sum   <= sum_d;
            out_cout  <= c[WIDTH];
`ifdef CLA_OVERFLOW_EN
            out_ovf   <= c[WIDTH] ^ c[WIDTH-1];
`endif
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed cases plus a randomized stream with
// random backpressure, scored against an arithmetic reference queue.
module tb_cla_pipe_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
`ifdef CLA_OVERFLOW_EN
    logic        out_ovf;
`endif

    int          tests;
    int          fails;
    int          pop_count;
    int          run_len;
    int          last_run;
    logic        rand_ready;
    logic [17:0] exp_q[$];
    logic        prev_stall;
    logic [15:0] prev_sum;
    logic        prev_cout;

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
`ifdef CLA_OVERFLOW_EN
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
`else
        .out_cout  (out_cout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Packed as {ovf, cout, sum}; overflow is the signed-range rule, not a carry equation.
    function automatic logic [17:0] refModel(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [16:0] u;
        logic        ovf;
        u   = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        ovf = (a[15] == b[15]) && (u[15] != a[15]);
        return {ovf, u};
    endfunction

    // Scoreboard: transfers are evaluated at the negedge, where inputs are settled for the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall <= 1'b0;
            run_len    <= 0;
        end else begin
            logic [17:0] e;
            checkOutput("in_ready", {31'd0, in_ready},
                        {31'd0, !(exp_q.size() == 2 && !out_ready)});
            if (prev_stall) begin
                checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
                checkOutput("stall_sum", {16'd0, out_sum}, {16'd0, prev_sum});
                checkOutput("stall_cout", {31'd0, out_cout}, {31'd0, prev_cout});
            end
            prev_stall <= out_valid && !out_ready;
            prev_sum   <= out_sum;
            prev_cout  <= out_cout;
            if (out_valid) begin
                run_len <= run_len + 1;
            end else begin
                if (run_len != 0) last_run <= run_len;
                run_len <= 0;
            end
            if (out_valid && out_ready) begin
                pop_count <= pop_count + 1;
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("sum", {16'd0, out_sum}, {16'd0, e[15:0]});
                    checkOutput("cout", {31'd0, out_cout}, {31'd0, e[16]});
`ifdef CLA_OVERFLOW_EN
                    checkOutput("ovf", {31'd0, out_ovf}, {31'd0, e[17]});
`endif
                end
            end
            if (in_valid && in_ready) exp_q.push_back(refModel(in_a, in_b, in_cin));
        end
    end

    // Random backpressure is driven later in the cycle than the operands to avoid racing main.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic ok;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) return;
        end
        checkOutput("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_a     = 'x;
        in_b     = 'x;
        in_cin   = 1'bx;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        checkOutput("drain_empty", exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pops_before;
        tests      = 0;
        fails      = 0;
        pop_count  = 0;
        last_run   = 0;
        rand_ready = 1'b0;
        rst_n      = 1'b0;
        out_ready  = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
            checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
            checkOutput("rst_out_sum", {16'd0, out_sum}, 32'd0);
        end

        applyStimulus(16'h1234, 16'h4321, 1'b0);
        idle();
        checkOutput("lat_s1_only", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("t2_sum", {16'd0, out_sum}, 32'h5555);
        checkOutput("t2_cout", {31'd0, out_cout}, 32'd0);

        applyStimulus(16'hFFFF, 16'h0000, 1'b1);
        idle();
        @(posedge clk);
        #1;
        checkOutput("t3_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("t3_sum", {16'd0, out_sum}, 32'h0000);
        checkOutput("t3_cout", {31'd0, out_cout}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom));
        end
        idle();
        waitDrain();
        checkOutput("burst_run", last_run, 32'd8);

        out_ready = 1'b0;
        applyStimulus(16'h00FF, 16'h0F0F, 1'b0);
        applyStimulus(16'h8000, 16'h8000, 1'b1);
        idle();
        checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("hold_sum", {16'd0, out_sum}, 32'h100E);
        pops_before = pop_count;
        out_ready   = 1'b1;
        waitDrain();
        checkOutput("drain_pops", pop_count - pops_before, 32'd2);

`ifdef CLA_OVERFLOW_EN
        applyStimulus(16'h7FFF, 16'h0001, 1'b0);
        idle();
        @(posedge clk);
        #1;
        checkOutput("t6_sum", {16'd0, out_sum}, 32'h8000);
        checkOutput("t6_ovf", {31'd0, out_ovf}, 32'd1);
        checkOutput("t6_cout", {31'd0, out_cout}, 32'd0);
`endif

        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                idle();
                @(posedge clk);
                #1;
            end
        end
        idle();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        waitDrain();

        out_ready = 1'b0;
        applyStimulus(16'h1111, 16'h2222, 1'b0);
        applyStimulus(16'h3333, 16'h4444, 1'b1);
        idle();
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        pops_before = pop_count;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("flushed_pops", pop_count - pops_before, 32'd0);
        applyStimulus(16'hABCD, 16'h1111, 1'b1);
        idle();
        @(posedge clk);
        #1;
        checkOutput("post_rst_sum", {16'd0, out_sum}, 32'hBCDF);
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
